// File: rtl/store_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// store_pkg : shared width encodings, entry state and entry record for stores
// Rev 1.0
// ----------------------------------------------------------------------------
package store_pkg;

  localparam logic [2:0] ST_B = 3'b000;
  localparam logic [2:0] ST_H = 3'b001;
  localparam logic [2:0] ST_W = 3'b010;
  localparam logic [2:0] ST_D = 3'b011;

  // Storage is sized for the widest supported XLEN; narrower builds use the low bits.
  localparam int MAX_XLEN = 64;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    PENDING   = 2'd1,
    COMMITTED = 2'd2
  } entry_state_t;

  typedef struct packed {
    logic [MAX_XLEN-1:0]   addr;
    logic [MAX_XLEN-1:0]   data;
    logic [MAX_XLEN/8-1:0] strb;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/store_lane_fmt.sv
`default_nettype none
// ----------------------------------------------------------------------------
// store_lane_fmt : combinational lane replication, byte strobes, alignment check
// Rev 1.0
// ----------------------------------------------------------------------------
module store_lane_fmt
  import store_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        width,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN-1:0]   wdata,
  output logic [XLEN/8-1:0] strb,
  output logic              exc
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  localparam logic [NB-1:0] B_MASK = NB'(1);
  localparam logic [NB-1:0] H_MASK = NB'(3);
  localparam logic [NB-1:0] W_MASK = NB'(15);

  logic [OFFW-1:0] off;
  logic            unused_addr;

  assign off         = addr[OFFW-1:0];
  assign unused_addr = ^addr;

  always_comb begin
    wdata = data;
    strb  = '0;
    exc   = 1'b0;
    case (width)
      ST_B: begin
        wdata = {NB{data[7:0]}};
        strb  = B_MASK << off;
      end
      ST_H: begin
        wdata = {(NB/2){data[15:0]}};
        strb  = H_MASK << off;
        exc   = off[0];
      end
      ST_W: begin
        wdata = {(NB/4){data[31:0]}};
        strb  = W_MASK << off;
        exc   = |off[1:0];
      end
      ST_D: begin
        strb = '1;
        exc  = (XLEN != 64) || (off != '0);
      end
      default: exc = 1'b1;
    endcase
    // Faulting stores never reach memory, so their strobes are meaningless.
    if (exc) strb = '0;
  end

endmodule
`default_nettype wire

// File: rtl/store_queue_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// store_queue_unit : store execution, registered ROB report, in-order commit queue
// Rev 1.0
// ----------------------------------------------------------------------------
module store_queue_unit
  import store_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_width,
  input  logic [TAG_W-1:0]  in_dest,
  input  logic [XLEN-1:0]   in_base,
  input  logic [XLEN-1:0]   in_data,
  input  logic [XLEN-1:0]   in_offset,
  output logic              rob_valid,
  output logic [TAG_W-1:0]  rob_dest,
  output logic [XLEN-1:0]   rob_addr,
  output logic [XLEN-1:0]   rob_data,
  output logic              rob_exc,
  input  logic              commit,
  input  logic              flush,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_strb
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  logic [XLEN-1:0] eff_addr;
  logic [XLEN-1:0] fmt_wdata;
  logic [NB-1:0]   fmt_strb;
  logic            fmt_exc;

  entry_t       entries [DEPTH];
  entry_state_t st      [DEPTH];
  entry_t       new_e;
  entry_t       head_e;

  logic [PW-1:0] head, cptr, tail;
  logic [CW-1:0] count, pend, flushed, count_nx;

  logic accept, enq, deq, has_pending, commit_fire;
  logic unused_head;

  assign eff_addr = in_base + in_offset;

  store_lane_fmt #(.XLEN(XLEN)) u_fmt (
    .width (in_width),
    .addr  (eff_addr),
    .data  (in_data),
    .wdata (fmt_wdata),
    .strb  (fmt_strb),
    .exc   (fmt_exc)
  );

  assign in_ready    = (count < CW'(DEPTH));
  // A flush in the same cycle squashes the incoming store entirely.
  assign accept      = in_valid && in_ready && !flush;
  assign enq         = accept && !fmt_exc;
  assign has_pending = (st[cptr] == PENDING);
  assign commit_fire = commit && has_pending;

  assign head_e      = entries[head];
  assign mem_valid   = (st[head] == COMMITTED);
  assign deq         = mem_valid && mem_ready;
  assign mem_addr    = mem_valid ? {head_e.addr[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
  assign mem_wdata   = mem_valid ? head_e.data[XLEN-1:0] : '0;
  assign mem_strb    = mem_valid ? head_e.strb[NB-1:0] : '0;
  assign unused_head = ^{head_e.addr, head_e.data, head_e.strb};

  always_comb begin
    new_e                 = '0;
    new_e.addr[XLEN-1:0]  = eff_addr;
    new_e.data[XLEN-1:0]  = fmt_wdata;
    new_e.strb[NB-1:0]    = fmt_strb;
  end

  // Everything pending except an entry committed this same cycle is discarded.
  always_comb begin
    flushed  = flush ? (pend - CW'(commit_fire)) : '0;
    count_nx = count + CW'(enq) - CW'(deq) - flushed;
  end

  always_ff @(posedge clk) begin
    if (enq) entries[tail] <= new_e;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head      <= '0;
      cptr      <= '0;
      tail      <= '0;
      count     <= '0;
      pend      <= '0;
      rob_valid <= 1'b0;
      rob_exc   <= 1'b0;
      rob_dest  <= '0;
      rob_addr  <= '0;
      rob_data  <= '0;
      for (int i = 0; i < DEPTH; i++) st[i] <= EMPTY;
    end else begin
      rob_valid <= accept;
      rob_exc   <= accept && fmt_exc;
      if (accept) begin
        rob_dest <= in_dest;
        rob_addr <= eff_addr;
        rob_data <= fmt_wdata;
      end

      if (enq) begin
        st[tail] <= PENDING;
        tail     <= tail + PW'(1);
      end
      if (commit_fire) begin
        st[cptr] <= COMMITTED;
        cptr     <= cptr + PW'(1);
      end
      if (deq) begin
        st[head] <= EMPTY;
        head     <= head + PW'(1);
      end
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (st[i] == PENDING && !(commit_fire && cptr == PW'(i))) st[i] <= EMPTY;
        end
        tail <= cptr + PW'(commit_fire);
      end

      count <= count_nx;
      pend  <= flush ? '0 : (pend + CW'(enq) - CW'(commit_fire));
    end
  end

  a_commit_has_pending: assert property (@(posedge clk) disable iff (!reset) commit |-> has_pending);

endmodule
`default_nettype wire

// File: tb/tb_store_queue_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_store_queue_unit : directed self-checking bench for store_queue_unit
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_store_queue_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_width;
  logic [TAG_W-1:0] in_dest;
  logic [XLEN-1:0]  in_base;
  logic [XLEN-1:0]  in_data;
  logic [XLEN-1:0]  in_offset;
  logic             rob_valid;
  logic [TAG_W-1:0] rob_dest;
  logic [XLEN-1:0]  rob_addr;
  logic [XLEN-1:0]  rob_data;
  logic             rob_exc;
  logic             commit;
  logic             flush;
  logic             mem_valid;
  logic             mem_ready;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;
  logic [3:0]       mem_strb;

  int tests = 0;
  int fails = 0;
  int nwr;

  store_queue_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_width  (in_width),
    .in_dest   (in_dest),
    .in_base   (in_base),
    .in_data   (in_data),
    .in_offset (in_offset),
    .rob_valid (rob_valid),
    .rob_dest  (rob_dest),
    .rob_addr  (rob_addr),
    .rob_data  (rob_data),
    .rob_exc   (rob_exc),
    .commit    (commit),
    .flush     (flush),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_strb  (mem_strb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] w, input logic [31:0] base, input logic [31:0] off,
                      input logic [31:0] data, input logic [5:0] dest);
    in_width  = w;
    in_base   = base;
    in_offset = off;
    in_data   = data;
    in_dest   = dest;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_width = 3'b0; in_dest = '0;
    in_base = '0; in_data = '0; in_offset = '0;
    commit = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    tick(); tick();

    check("rst_in_ready",  in_ready,  1);
    check("rst_rob_valid", rob_valid, 0);
    check("rst_rob_exc",   rob_exc,   0);
    check("rst_rob_addr",  rob_addr,  0);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr",  mem_addr,  0);
    check("rst_mem_strb",  mem_strb,  0);
    check("rst_count",     dut.count, 0);
    reset = 1'b1;
    tick();

    // SW 0x1000 + 4
    send(3'b010, 32'h1000, 32'h4, 32'hDEADBEEF, 6'd5);
    check("sw_rob_valid", rob_valid, 1);
    check("sw_rob_addr",  rob_addr,  32'h1004);
    check("sw_rob_exc",   rob_exc,   0);
    check("sw_rob_data",  rob_data,  32'hDEADBEEF);
    check("sw_rob_dest",  rob_dest,  5);
    check("sw_pend_nomem", mem_valid, 0);
    tick();
    check("sw_rob_pulse", rob_valid, 0);
    commit = 1'b1; tick(); commit = 1'b0;
    check("sw_mem_valid", mem_valid, 1);
    check("sw_mem_addr",  mem_addr,  32'h1004);
    check("sw_mem_strb",  mem_strb,  4'b1111);
    check("sw_mem_wdata", mem_wdata, 32'hDEADBEEF);
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    check("sw_drained", mem_valid, 0);

    // SB to 0x1003
    send(3'b000, 32'h1000, 32'h3, 32'h000000A5, 6'd6);
    check("sb_rob_data", rob_data, 32'hA5A5A5A5);
    check("sb_rob_exc",  rob_exc,  0);
    commit = 1'b1; tick(); commit = 1'b0;
    check("sb_mem_strb",  mem_strb,  4'b1000);
    check("sb_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    check("sb_mem_addr",  mem_addr,  32'h1000);
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;

    // SH to 0x1002 (aligned)
    send(3'b001, 32'h1000, 32'h2, 32'h1234BEEF, 6'd7);
    check("sh_rob_exc", rob_exc, 0);
    commit = 1'b1; tick(); commit = 1'b0;
    check("sh_mem_strb",  mem_strb,  4'b1100);
    check("sh_mem_wdata", mem_wdata, 32'hBEEFBEEF);
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;

    // Misaligned SH, SD on 32-bit, reserved width
    send(3'b001, 32'h1000, 32'h1, 32'h0000BEEF, 6'd8);
    check("shmis_rob_valid", rob_valid, 1);
    check("shmis_rob_exc",   rob_exc,   1);
    check("shmis_count",     dut.count, 0);
    send(3'b011, 32'h2000, 32'h0, 32'h1, 6'd9);
    check("sd32_rob_exc", rob_exc, 1);
    send(3'b100, 32'h2000, 32'h0, 32'h1, 6'd10);
    check("badw_rob_exc", rob_exc, 1);
    tick(); tick();
    check("exc_no_mem", mem_valid, 0);
    check("exc_count",  dut.count, 0);
    check("exc_ready",  in_ready,  1);

    // Fill queue with memory stalled
    for (int i = 0; i < DEPTH; i++) begin
      check("fill_ready", in_ready, 1);
      send(3'b010, 32'h2000, 32'(i * 4), 32'h11110000 + 32'(i), 6'(i));
    end
    check("full_not_ready", in_ready, 0);
    send(3'b010, 32'h2100, 32'h0, 32'h0, 6'd20);
    check("full_no_rob", rob_valid, 0);
    commit = 1'b1; tick(); commit = 1'b0;
    check("stall_valid", mem_valid, 1);
    check("stall_addr0", mem_addr, 32'h2000);
    tick();
    check("stall_hold_v", mem_valid, 1);
    check("stall_hold_a", mem_addr, 32'h2000);
    check("stall_hold_d", mem_wdata, 32'h11110000);
    nwr = 1;
    mem_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      commit = (c < 3);
      tick();
      if (mem_valid) begin
        check("drain_addr",  mem_addr,  32'h2000 + 32'(nwr * 4));
        check("drain_wdata", mem_wdata, 32'h11110000 + 32'(nwr));
        nwr++;
      end
    end
    commit = 1'b0; mem_ready = 1'b0;
    check("drain_writes", nwr, 4);
    check("drain_ready",  in_ready, 1);
    check("drain_count",  dut.count, 0);

    // Reset while a committed store is stalled
    send(3'b010, 32'h4000, 32'h0, 32'h55AA55AA, 6'd1);
    commit = 1'b1; tick(); commit = 1'b0;
    check("mid_mem_valid", mem_valid, 1);
    reset = 1'b0; tick();
    check("mid_rst_valid", mem_valid, 0);
    check("mid_rst_ready", in_ready,  1);
    check("mid_rst_count", dut.count, 0);
    reset = 1'b1; tick();

    // 3 enqueued, 1 committed, then commit + flush
    for (int i = 0; i < 3; i++) send(3'b000, 32'h3000, 32'(i), 32'h40 + 32'(i), 6'(i));
    commit = 1'b1; tick();
    flush = 1'b1; tick();
    commit = 1'b0; flush = 1'b0;
    check("cf_tail",  dut.tail,  2);
    check("cf_cptr",  dut.cptr,  2);
    check("cf_count", dut.count, 2);
    nwr = 0;
    mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (mem_valid) begin
        check("cf_strb",  mem_strb,  4'(1 << nwr));
        check("cf_wdata", mem_wdata, {4{8'h40 + 8'(nwr)}});
        nwr++;
      end
      tick();
    end
    mem_ready = 1'b0;
    check("cf_writes", nwr, 2);

    // Accept coinciding with flush is dropped
    flush = 1'b1;
    send(3'b010, 32'h5000, 32'h0, 32'h1, 6'd3);
    flush = 1'b0;
    check("af_no_rob", rob_valid, 0);
    check("af_count",  dut.count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_queue_unit.md
# store_queue_unit

Parametrised store execution unit and in-order store queue. Takes store micro-ops from the reservation station, computes the effective address, and produces byte-lane data and strobes. It reports completion (or an alignment/width exception) to the ROB one cycle later. Legal stores are held in a DEPTH-entry queue until the ROB commits them; they then drain to the data-memory write port over a valid/ready handshake. This replaces the purely combinational store path between the reservation station and the ROB.

## Interface
Parameters:
- XLEN, 32, data/address width; 32 or 64 only.
- TAG_W, 6, ROB destination tag width.
- DEPTH, 4, queue entries; power of two, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  store micro-op present.
- in_ready  out  1  queue can accept; `count < DEPTH`.
- in_width  in  3  funct3: 000 SB, 001 SH, 010 SW, 011 SD (legal only when XLEN=64).
- in_dest  in  TAG_W  ROB tag.
- in_base  in  XLEN  rs1 value.
- in_data  in  XLEN  rs2 value.
- in_offset  in  XLEN  sign-extended immediate.
- rob_valid  out  1  completion report valid (one-cycle pulse).
- rob_dest  out  TAG_W  tag of reported store.
- rob_addr  out  XLEN  effective address.
- rob_data  out  XLEN  lane-aligned store data.
- rob_exc  out  1  misaligned or illegal width.
- commit  in  1  ROB retires the oldest pending store.
- flush  in  1  discard all pending (uncommitted) entries.
- mem_valid  out  1  committed store presented to memory.
- mem_ready  in  1  memory accepts.
- mem_addr  out  XLEN  address with the low log2(XLEN/8) bits cleared.
- mem_wdata  out  XLEN  lane-aligned data.
- mem_strb  out  XLEN/8  byte strobes.

## Operation
- Accept occurs when `in_valid && in_ready`.
  - `addr = in_base + in_offset`, modulo 2^XLEN.
  - `off = addr[log2(XLEN/8)-1:0]`.
- Lane formatting:
  - SB: byte replicated across all lanes; `strb = 1 << off`.
  - SH: halfword replicated; `strb = 2'b11 << off`.
  - SW: word replicated (XLEN=64); `strb = 4'hF << off`.
  - SD: `strb` all ones.
  - Data is never sign-extended.
- Exceptions:
  - `exc = 1` when off is not a multiple of the access size.
  - `exc = 1` when in_width is not legal for the XLEN.
- Excepting stores are reported to the ROB but not enqueued. They do not consume an entry.
- Legal stores are enqueued at the tail in state PENDING. The entry holds {addr, data, strb}.
- Each entry holds one of three states:
  - EMPTY → PENDING on enqueue.
  - PENDING → COMMITTED on commit; applies to the oldest PENDING entry, via the commit pointer.
  - COMMITTED → EMPTY on the head handshake `mem_valid && mem_ready`.
- Pointers:
  - head, cptr and tail are each log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits and distinguishes full from empty.
- `mem_valid = 1` iff the head entry is COMMITTED. mem_* fields are driven from the head entry.
- flush: all PENDING entries become EMPTY and tail ← cptr. COMMITTED entries still drain.
- Simultaneous events:
  - commit + flush: commit applies first. The oldest pending entry becomes COMMITTED; the rest are flushed.
  - accept + flush: the incoming store is dropped, with no rob_valid and no enqueue.
  - enqueue + dequeue when full: in_ready stays 0 that cycle. in_ready is not combinationally dependent on mem_ready.
  - commit with no PENDING entry: ignored. Simulation assertion fires.
- Reset mid-operation discards every entry, including COMMITTED ones. The ROB is also reset.

## Timing
- Reset values:
  - in_ready = 1.
  - rob_valid = 0, rob_exc = 0.
  - rob_dest/addr/data = 0.
  - mem_valid = 0, mem_addr/wdata = 0, mem_strb = 0.
  - All pointers and count = 0.
- ROB report is registered: accept at cycle N → rob_valid = 1 for exactly cycle N+1.
- An entry enqueued at N is eligible for commit from cycle N+1.
- Commit at cycle C → mem_valid at C+1 at the earliest, when that entry is at head.
- mem_* fields are held stable while `mem_valid && !mem_ready`.
- Throughput:
  - One accept per cycle.
  - One commit per cycle.
  - One memory write per cycle.

## Structure
- Package `store_pkg` holds:
  - width encodings (`ST_B`, `ST_H`, `ST_W`, `ST_D`);
  - the entry-state enum {EMPTY, PENDING, COMMITTED};
  - the entry struct {addr, data, strb}.
- Sub-module `store_lane_fmt` is combinational: (width, addr, data) → (wdata, strb, exc). It is shared with the future load-alignment checker.
- The top level holds the queue array, pointers, the registered ROB report and the handshake logic.

## Test plan
- SW: base 0x1000, offset 0x4, data 0xDEADBEEF. Response:
  - cycle+1: rob_addr = 0x1004, rob_exc = 0.
  - After commit: mem_addr = 0x1004, mem_strb = 4'b1111, mem_wdata = 0xDEADBEEF.
- SB to 0x1003 with data 0x000000A5 → mem_strb = 4'b1000, mem_wdata = 0xA5A5A5A5.
- SH to 0x1001 → rob_exc = 1. count unchanged. No mem_valid after any commit.
- Fill 4 stores with mem_ready = 0 → in_ready = 0 after the 4th. Then commit ×4 and hold mem_ready = 1 → 4 writes in order, in_ready returns to 1.
- 3 enqueued, 1 committed, then commit + flush in the same cycle → exactly 2 memory writes occur; tail == cptr afterwards.
- Reset asserted while mem_valid = 1 and mem_ready = 0 → next cycle mem_valid = 0, in_ready = 1, count = 0.
